posit32_round_encode: RTL and testbench

POSIT32_ROUND_ENCODE -- requirements
Module: posit32_round_encode

---
 rtl/posit32_round_encode.sv | 173 +++++++++++++++++
 tb/tb_posit32_round_encode.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/posit32_round_encode.sv
// Posit32 (es=2) round-and-encode back end: scale/fraction in, rounded posit word out, 2-stage pipeline.
// Optional feature: define POSIT32_ROUND_ENCODE_SKID_EN for a registered in_ready with a 2-entry output skid buffer.
module posit32_round_encode #(
   parameter int ES     = 2,
   parameter int FRAC_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [9:0]        in_scale,
   input  logic [FRAC_W-1:0] in_frac,
   input  logic              in_sticky,
   input  logic              in_zero,
   input  logic              in_nar,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_posit,
   output logic              out_inexact
);

   localparam int unsigned EW = FRAC_W + 35;

   if (ES != 2) begin : g_es_check
      $error("posit32_round_encode: only ES=2 is supported");
   end

   logic              s1_valid, s1_sign, s1_neg, s1_sticky, s1_zero, s1_nar, s1_hi, s1_lo;
   logic [4:0]        s1_sh;
   logic [1:0]        s1_exp;
   logic [FRAC_W-1:0] s1_frac;
   logic              s2_valid, s2_inexact;
   logic [31:0]       s2_posit;
   logic              adv, s1_load, accept;
   logic              scale_hi, scale_lo;
   logic [4:0]        sh_in;

   logic [EW-1:0]     base, shifted;
   logic [30:0]       field, mag, mag_f;
   logic              guard, rest, round_up;
   logic [31:0]       res_posit;
   logic              res_inexact;

   // k = scale>>>2; shift is k for k>=0 and -k-1 (bitwise ~k) for k<0.
   assign scale_hi = $signed(in_scale) > 10'sd120;
   assign scale_lo = $signed(in_scale) < -10'sd120;
   assign sh_in    = in_scale[9] ? ~in_scale[6:2] : in_scale[6:2];

   assign s1_load  = !s1_valid | adv;
   assign accept   = in_valid & in_ready;

   // Arithmetic shift of {10|01, e, frac} replicates the leading regime bit k (or -k-1) times.
   always_comb begin
      base     = {(s1_neg ? 2'b01 : 2'b10), s1_exp, s1_frac, 31'd0};
      shifted  = $signed(base) >>> s1_sh;
      field    = shifted[EW-1 -: 31];
      guard    = shifted[EW-32];
      rest     = (|shifted[EW-33:0]) | s1_sticky;
      round_up = guard & (rest | field[0]);
      mag      = field + {30'd0, round_up};
   end

   always_comb begin
      res_posit   = '0;
      res_inexact = 1'b0;
      mag_f       = mag;
      if (s1_nar) begin
         res_posit = 32'h8000_0000;
      end else if (!s1_zero) begin
         if (s1_hi) begin
            mag_f       = '1;
            res_inexact = 1'b1;
         end else if (s1_lo) begin
            mag_f       = 31'd1;
            res_inexact = 1'b1;
         end else begin
            res_inexact = guard | rest;
         end
         res_posit = s1_sign ? (32'd0 - {1'b0, mag_f}) : {1'b0, mag_f};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_sign    <= 1'b0;
         s1_neg     <= 1'b0;
         s1_sticky  <= 1'b0;
         s1_zero    <= 1'b0;
         s1_nar     <= 1'b0;
         s1_hi      <= 1'b0;
         s1_lo      <= 1'b0;
         s1_sh      <= '0;
         s1_exp     <= '0;
         s1_frac    <= '0;
         s2_valid   <= 1'b0;
         s2_posit   <= '0;
         s2_inexact <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
               s1_sign   <= in_sign;
               s1_neg    <= in_scale[9];
               s1_sticky <= in_sticky;
               s1_zero   <= in_zero;
               s1_nar    <= in_nar;
               s1_hi     <= scale_hi;
               s1_lo     <= scale_lo;
               s1_sh     <= sh_in;
               s1_exp    <= in_scale[1:0];
               s1_frac   <= in_frac;
            end
         end
         if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_posit   <= res_posit;
               s2_inexact <= res_inexact;
            end
         end
      end
   end

`ifdef POSIT32_ROUND_ENCODE_SKID_EN
   logic [32:0] sk_mem [0:1];
   logic        sk_head, sk_any, pop, sk_pop, s2_direct, push, full_q;
   logic [1:0]  sk_cnt, sk_cnt_n;
   logic        s1_valid_n, s2_valid_n;
   logic [2:0]  occ_n;

   // Skid entries are older than S2, so they are presented first; S2 goes straight out only when the skid is empty.
   assign sk_any    = (sk_cnt != 2'd0);
   assign out_valid = sk_any | s2_valid;
   assign {out_inexact, out_posit} = sk_any ? sk_mem[sk_head] : {s2_inexact, s2_posit};
   assign pop       = out_valid & out_ready;
   assign sk_pop    = pop & sk_any;
   assign s2_direct = s2_valid & !sk_any & out_ready;
   assign adv       = !s2_valid | s2_direct | (sk_cnt != 2'd2) | sk_pop;
   assign push      = s2_valid & !s2_direct & adv;
   assign in_ready  = !rst & !full_q;

   always_comb begin
      s1_valid_n = s1_load ? accept : s1_valid;
      s2_valid_n = adv ? s1_valid : s2_valid;
      sk_cnt_n   = sk_cnt + {1'b0, push} - {1'b0, sk_pop};
      occ_n      = {2'd0, s1_valid_n} + {2'd0, s2_valid_n} + {1'b0, sk_cnt_n};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sk_mem[0] <= '0;
         sk_mem[1] <= '0;
         sk_head   <= 1'b0;
         sk_cnt    <= '0;
         full_q    <= 1'b0;
      end else begin
         if (push) sk_mem[sk_head ^ sk_cnt[0]] <= {s2_inexact, s2_posit};
         if (sk_pop) sk_head <= !sk_head;
         sk_cnt <= sk_cnt_n;
         full_q <= (occ_n == 3'd4);
      end
   end
`else
   assign adv         = !s2_valid | out_ready;
   assign in_ready    = !rst & (!s1_valid | adv);
   assign out_valid   = s2_valid;
   assign out_posit   = s2_posit;
   assign out_inexact = s2_inexact;
`endif

endmodule

// File: tb/tb_posit32_round_encode.sv
// Testbench for posit32_round_encode: directed vectors, backpressure, reset, and a randomized scoreboard run.
module tb_posit32_round_encode;

   logic        clk, rst;
   logic        in_valid, in_ready, in_sign, in_sticky, in_zero, in_nar;
   logic [9:0]  in_scale;
   logic [31:0] in_frac;
   logic        out_valid, out_ready, out_inexact;
   logic [31:0] out_posit;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_out    = 0;
   logic [32:0] exp_q[$];
   logic        held = 1'b0;
   logic [32:0] held_val;
   logic        last_rdy, last_acc;

   posit32_round_encode #(.ES(2), .FRAC_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_scale(in_scale), .in_frac(in_frac),
      .in_sticky(in_sticky), .in_zero(in_zero), .in_nar(in_nar),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_posit(out_posit), .out_inexact(out_inexact)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: spell out the posit bit string (regime, exponent, fraction) then round it to 31 bits.
   function automatic logic [32:0] ref_encode(input logic sg, input logic [9:0] sc, input logic [31:0] fr,
                                              input logic st, input logic z, input logic n);
      int          s, k, e;
      bit          bits[$];
      longint      m;
      bit          g, r;
      logic        inx;
      logic [31:0] w;
      s = int'($signed(sc));
      if (n) return {1'b0, 32'h8000_0000};
      if (z) return 33'd0;
      if (s > 120) begin
         m = 64'h7FFF_FFFF; inx = 1'b1;
      end else if (s < -120) begin
         m = 1; inx = 1'b1;
      end else begin
         k = (s >= 0) ? s / 4 : -((3 - s) / 4);
         e = s - 4 * k;
         if (k >= 0) begin
            repeat (k + 1) bits.push_back(1'b1);
            bits.push_back(1'b0);
         end else begin
            repeat (-k) bits.push_back(1'b0);
            bits.push_back(1'b1);
         end
         bits.push_back(e[1]);
         bits.push_back(e[0]);
         for (int i = 31; i >= 0; i--) bits.push_back(fr[i]);
         m = 0;
         for (int i = 0; i < 31; i++) m = m * 2 + longint'(bits[i]);
         g = bits[31];
         r = st;
         for (int i = 32; i < bits.size(); i++) r |= bits[i];
         inx = g | r;
         if (g && (r || (m % 2 == 1))) m++;
         if (m == 0) m = 1;
         if (m > 64'h7FFF_FFFF) m = 64'h7FFF_FFFF;
      end
      w = m[31:0];
      if (sg) w = 32'd0 - w;
      return {inx, w};
   endfunction

   // Called just after a negedge with inputs already driven; returns at the next negedge.
   task automatic tick();
      #1;
      if (held) begin
         check("hold_valid", {63'd0, out_valid}, 64'd1);
         check("hold_data", {31'd0, out_inexact, out_posit}, {31'd0, held_val});
         held = 1'b0;
      end
      if (out_valid) begin
         if (out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check("spurious_out", {63'd0, out_valid}, 64'd0);
            else check("result", {31'd0, out_inexact, out_posit}, {31'd0, exp_q.pop_front()});
         end else begin
            held     = 1'b1;
            held_val = {out_inexact, out_posit};
         end
      end
      last_rdy = in_ready;
      last_acc = in_valid & in_ready;
      if (last_acc) exp_q.push_back(ref_encode(in_sign, in_scale, in_frac, in_sticky, in_zero, in_nar));
      @(negedge clk);
   endtask

   task automatic directed(input string tag, input logic sg, input logic [9:0] sc, input logic [31:0] fr,
                           input logic st, input logic z, input logic n,
                           input logic [31:0] exp_w, input logic exp_x);
      in_valid = 1'b1; in_sign = sg; in_scale = sc; in_frac = fr;
      in_sticky = st; in_zero = z; in_nar = n; out_ready = 1'b1;
      #1 check({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check({tag, "_early"}, {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      #1;
      check({tag, "_lat"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_word"}, {32'd0, out_posit}, {32'd0, exp_w});
      check({tag, "_inx"}, {63'd0, out_inexact}, {63'd0, exp_x});
      @(negedge clk);
   endtask

   task automatic rand_inputs();
      int sel;
      sel       = $urandom_range(0, 15);
      in_sign   = 1'($urandom);
      in_scale  = (sel == 0) ? 10'($urandom) : 10'(int'($urandom_range(0, 260)) - 130);
      in_frac   = (sel == 2) ? ($urandom & 32'hFFFF_0000) : $urandom;
      in_sticky = ($urandom_range(0, 3) == 0);
      in_zero   = ($urandom_range(0, 19) == 0);
      in_nar    = ($urandom_range(0, 29) == 0);
   endtask

   initial begin
      int sent, got0, start;
      logic saw_block;
      rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_scale = '0; in_frac = '0;
      in_sticky = 1'b0; in_zero = 1'b0; in_nar = 1'b0; out_ready = 1'b0;
      @(negedge clk); @(negedge clk);
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_posit", {32'd0, out_posit}, 64'd0);
      check("rst_inexact", {63'd0, out_inexact}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("rdy_after_rst", {63'd0, in_ready}, 64'd1);
      @(negedge clk);

      directed("one",       1'b0, 10'd0,        32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 1'b0);
      directed("neg24",     1'b1, 10'd4,        32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h9E00_0000, 1'b0);
      directed("neg32",     1'b1, 10'd5,        32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h9C00_0000, 1'b0);
      directed("clamp_hi",  1'b0, 10'd121,      32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1);
      directed("clamp_lo",  1'b0, 10'(-130),    32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1'b1);
      directed("clamp_neg", 1'b1, 10'd200,      32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0001, 1'b1);
      directed("maxpos",    1'b0, 10'd120,      32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0);
      directed("minpos",    1'b0, 10'(-120),    32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1'b0);
      directed("nar_zero",  1'b1, 10'd33,       32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0);
      directed("zero",      1'b1, 10'd33,       32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0);
      directed("tie_odd",   1'b0, 10'd0,        32'h0000_0030, 1'b0, 1'b0, 1'b0, 32'h4000_0002, 1'b1);
      directed("tie_even",  1'b0, 10'd0,        32'h0000_0010, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 1'b1);
      directed("above_half",1'b0, 10'd0,        32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'h4000_0001, 1'b1);
      directed("exact_lsb", 1'b0, 10'd0,        32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h4000_0001, 1'b0);

      // Backpressure: out_ready low for the first 5 cycles while 4 inputs are offered back to back.
      held = 1'b0; sent = 0; got0 = n_out; saw_block = 1'b0;
      for (int c = 0; c < 40 && (n_out - got0) < 4; c++) begin
         out_ready = (c >= 5);
         in_valid  = (sent < 4);
         in_sign   = sent[0]; in_scale = 10'(sent * 9 - 12); in_frac = 32'hA5A5_0000 + 32'(sent);
         in_sticky = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
         tick();
         if (sent < 4 && !last_rdy) saw_block = 1'b1;
         if (last_acc) sent++;
      end
      in_valid = 1'b0;
      check("stall_in_ready_drop", {63'd0, saw_block}, 64'd1);
      check("stall_count", 64'(n_out - got0), 64'd4);

      // Randomized stream against the reference model.
      in_valid = 1'b0; last_acc = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!in_valid || last_acc) begin
            in_valid = ($urandom_range(0, 9) < 7);
            rand_inputs();
         end
         out_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
      check("drain", 64'(exp_q.size()), 64'd0);

      // Reset in the middle of a stream.
      start = n_out;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         rand_inputs();
         tick();
      end
      check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("mid_rst_posit", {32'd0, out_posit}, 64'd0);
      check("mid_rst_inexact", {63'd0, out_inexact}, 64'd0);
      exp_q.delete();
      held = 1'b0;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      #1 check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      for (int c = 0; c < 4; c++) tick();
      check("post_rst_no_output", 64'(n_out - start), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
